// File: rtl/main_regs_sequencer.sv
// Control FSM for the x1..x4 register bank: clear, load operands, step the datapath
// NUM_ITERS times, then pulse done. Outputs are state-decoded except the RUN-state en.
module main_regs_sequencer #(
  parameter int NUM_ITERS = 8,
  parameter int ITER_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              dp_valid,
  output logic              ready,
  output logic              busy,
  output logic              clr,
  output logic              en,
  output logic              sel_init,
  output logic [ITER_W-1:0] iter,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One extra counter bit lets the count reach NUM_ITERS even when it equals 2**ITER_W.
  localparam int              CNT_W    = ITER_W + 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_ITERS - 1);
  localparam logic [CNT_W-1:0] ITER_MAX = {1'b0, {ITER_W{1'b1}}};

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             step;

  // An abort in RUN suppresses the step even when a result is on offer.
  assign step = (state == S_RUN) && dp_valid && !abort;

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = start ? S_CLEAR : S_IDLE;
      S_CLEAR: state_next = abort ? S_IDLE : S_LOAD;
      S_LOAD:  state_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)
          state_next = S_IDLE;
        else if (dp_valid && (count == LAST))
          state_next = S_DONE;
        else
          state_next = S_RUN;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if ((state == S_CLEAR) && !abort)
      count_next = '0;
    else if (step)
      count_next = count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  assign ready    = (state == S_IDLE);
  assign busy     = (state == S_CLEAR) || (state == S_LOAD) || (state == S_RUN);
  assign clr      = (state == S_CLEAR);
  assign en       = (state == S_LOAD) || step;
  assign sel_init = (state == S_LOAD);
  assign done     = (state == S_DONE);
  assign iter     = (count > ITER_MAX) ? ITER_MAX[ITER_W-1:0] : count[ITER_W-1:0];

endmodule

// File: tb/tb_main_regs_sequencer.sv
// Drives three sequencer instances (NUM_ITERS 3, 1 and 16) from shared inputs and
// compares every output each cycle against a per-instance run model.
module tb_main_regs_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic dp_valid;

  always #5 clk = ~clk;

  // Flag order per instance: {ready, busy, clr, en, sel_init, done}
  wire [5:0] f0, f1, f2;
  wire [3:0] it0, it2;
  wire [0:0] it1;

  main_regs_sequencer #(.NUM_ITERS(3), .ITER_W(4)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_valid(dp_valid),
    .ready(f0[5]), .busy(f0[4]), .clr(f0[3]), .en(f0[2]), .sel_init(f0[1]),
    .iter(it0), .done(f0[0]));

  main_regs_sequencer #(.NUM_ITERS(1), .ITER_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_valid(dp_valid),
    .ready(f1[5]), .busy(f1[4]), .clr(f1[3]), .en(f1[2]), .sel_init(f1[1]),
    .iter(it1), .done(f1[0]));

  main_regs_sequencer #(.NUM_ITERS(16), .ITER_W(4)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dp_valid(dp_valid),
    .ready(f2[5]), .busy(f2[4]), .clr(f2[3]), .en(f2[2]), .sel_init(f2[1]),
    .iter(it2), .done(f2[0]));

  typedef enum {M_IDLE, M_CLEAR, M_LOAD, M_RUN, M_DONE} phase_t;

  phase_t ph[3];
  int     steps[3];
  int     num_iters[3] = '{3, 1, 16};
  int     iter_cap[3]  = '{15, 1, 15};
  int     total = 0;
  int     bad   = 0;
  int     cyc;
  int     done_cnt[3];
  int     done_cyc[3];
  int     en_run_cnt[3];

  function automatic logic [5:0] flagsOf(input int k);
    case (k)
      0:       return f0;
      1:       return f1;
      default: return f2;
    endcase
  endfunction

  function automatic int iterOf(input int k);
    case (k)
      0:       return int'(it0);
      1:       return int'(it1);
      default: return int'(it2);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < 3; k++) begin
      ph[k]    = M_IDLE;
      steps[k] = 0;
    end
  endtask

  task automatic clearStats();
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      done_cnt[k]   = 0;
      done_cyc[k]   = -1;
      en_run_cnt[k] = 0;
    end
  endtask

  task automatic checkAll();
    logic [5:0] f;
    logic       exp_en;
    int         exp_iter;
    for (int k = 0; k < 3; k++) begin
      f        = flagsOf(k);
      exp_en   = (ph[k] == M_LOAD) || (ph[k] == M_RUN && dp_valid && !abort);
      exp_iter = (steps[k] < iter_cap[k]) ? steps[k] : iter_cap[k];
      checkOutput($sformatf("ready%0d", k), 32'(f[5]), 32'(ph[k] == M_IDLE));
      checkOutput($sformatf("busy%0d", k), 32'(f[4]),
                  32'(ph[k] == M_CLEAR || ph[k] == M_LOAD || ph[k] == M_RUN));
      checkOutput($sformatf("clr%0d", k), 32'(f[3]), 32'(ph[k] == M_CLEAR));
      checkOutput($sformatf("en%0d", k), 32'(f[2]), 32'(exp_en));
      checkOutput($sformatf("sel_init%0d", k), 32'(f[1]), 32'(ph[k] == M_LOAD));
      checkOutput($sformatf("done%0d", k), 32'(f[0]), 32'(ph[k] == M_DONE));
      checkOutput($sformatf("iter%0d", k), 32'(iterOf(k)), 32'(exp_iter));
      checkOutput($sformatf("clr_en_excl%0d", k), 32'(f[3] & f[2]), 32'd0);
      if (f[0]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
      if (f[2] && !f[1]) en_run_cnt[k]++;
    end
  endtask

  // Advance the run model by one clock using the inputs that were sampled at that edge.
  task automatic stepModel();
    if (rst) return;
    for (int k = 0; k < 3; k++) begin
      case (ph[k])
        M_IDLE:  if (start) ph[k] = M_CLEAR;
        M_CLEAR: if (abort) ph[k] = M_IDLE;
                 else begin ph[k] = M_LOAD; steps[k] = 0; end
        M_LOAD:  ph[k] = abort ? M_IDLE : M_RUN;
        M_RUN: begin
          if (abort) ph[k] = M_IDLE;
          else if (dp_valid) begin
            steps[k]++;
            if (steps[k] == num_iters[k]) ph[k] = M_DONE;
          end
        end
        default: ph[k] = M_IDLE;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic d);
    @(negedge clk);
    start    = s;
    abort    = a;
    dp_valid = d;
    #1 checkAll();
    cyc++;
    @(posedge clk);
    stepModel();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; dp_valid = 1'b0;
    resetModel();
    clearStats();
    #1 checkAll();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic run, dp_valid held high");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (24) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_done_cycle_n3", 32'(done_cyc[0]), 32'd6);
    checkOutput("t1_done_cycle_n1", 32'(done_cyc[1]), 32'd4);
    checkOutput("t1_done_cycle_n16", 32'(done_cyc[2]), 32'd19);
    checkOutput("t1_done_count_n3", 32'(done_cnt[0]), 32'd1);
    checkOutput("t1_run_en_n1", 32'(en_run_cnt[1]), 32'd1);

    $display("[TB] sparse dp_valid");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, (i % 3) == 2);
    checkOutput("t2_run_en_n3", 32'(en_run_cnt[0]), 32'd3);
    checkOutput("t2_done_count_n3", 32'(done_cnt[0]), 32'd1);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] abort after two steps");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_iter_held_n3", 32'(it0), 32'd2);
    checkOutput("t3_no_done_n3", 32'(done_cnt[0]), 32'd0);

    $display("[TB] start ignored while busy, start+abort in idle");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4_single_done_n3", 32'(done_cnt[0]), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t4_start_beats_abort", 32'(f0[3]), 32'd1);
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] async reset mid-run");
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    resetModel();
    #1 checkAll();
    checkOutput("t5_iter_cleared", 32'(it0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearStats();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (22) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_restart_done_cycle", 32'(done_cyc[0]), 32'd6);
    checkOutput("t5_restart_done_count", 32'(done_cnt[0]), 32'd1);

    $display("[TB] random start/abort/dp_valid");
    for (int i = 0; i < 1000; i++)
      applyStimulus($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(1) == 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
